// File: rtl/mult_div_unit_pkg.sv
// Shared codes for the multiply/divide unit: controller ctrl encodings and FSM states.
package mult_div_unit_pkg;

  localparam int MD_WIDTH = 32;

  // The controller drives these on div_mult_ctrl; MD_RSVD behaves like MD_IDLE.
  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_MULT = 2'b01,
    MD_DIV  = 2'b10,
    MD_RSVD = 2'b11
  } md_ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } md_state_t;

endpackage

// File: rtl/mult_div_unit_booth_step.sv
// One radix-2 Booth iteration on the {hi, lo, q-1} register followed by an arithmetic right shift.
module mult_div_unit_booth_step
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [2*WIDTH:0] acc,
  input  logic [WIDTH-1:0] mcand,
  output logic [2*WIDTH:0] acc_next
);

  logic [WIDTH:0] hi_ext;
  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] sum;

  // The add/sub is one bit wider so that subtracting the most negative multiplicand
  // keeps the correct sign bit for the shift.
  always_comb begin
    hi_ext = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
    m_ext  = {mcand[WIDTH-1], mcand};
    case (acc[1:0])
      2'b01:   sum = hi_ext + m_ext;
      2'b10:   sum = hi_ext - m_ext;
      default: sum = hi_ext;
    endcase
    acc_next = {sum, acc[WIDTH:1]};
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle signed multiplier (Booth) and divider (restoring) feeding the Hi/Lo registers.
// Handshake: the controller holds ctrl nonzero until done; done is a one-cycle registered pulse.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       ctrl,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output md_state_t        fsm_state
);

  localparam int CW = $clog2(WIDTH);
  localparam int AW = 2*WIDTH + 1;

  md_state_t        state;
  logic [CW-1:0]    counter;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    booth_next;
  logic [AW-1:0]    div_next;
  logic [AW-1:0]    step_next;
  logic [WIDTH-1:0] mcand;
  logic             op_div;
  logic             a_neg;
  logic             b_neg;
  logic             zero_pend;

  logic [WIDTH:0]   div_shifted;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH-1:0] raw_hi;
  logic [WIDTH-1:0] raw_lo;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  mult_div_unit_booth_step #(.WIDTH(WIDTH)) u_booth_step (
    .acc      (acc),
    .mcand    (mcand),
    .acc_next (booth_next)
  );

  // The divider reuses acc: hi field holds the partial remainder, lo field shifts the
  // dividend out while quotient bits shift in. Magnitudes only; signs are applied at the end.
  always_comb begin
    a_abs       = a_in[WIDTH-1] ? -a_in : a_in;
    b_abs       = b_in[WIDTH-1] ? -b_in : b_in;
    div_shifted = {acc[AW-1:WIDTH+1], acc[WIDTH]};
    div_trial   = div_shifted - {1'b0, mcand};
    div_rem     = div_trial[WIDTH] ? div_shifted[WIDTH-1:0] : div_trial[WIDTH-1:0];
    div_next    = {div_rem, acc[WIDTH-1:1], ~div_trial[WIDTH], 1'b0};
    step_next   = op_div ? div_next : booth_next;
    raw_hi      = step_next[AW-1:WIDTH+1];
    raw_lo      = step_next[WIDTH:1];
    if (op_div) begin
      res_hi = a_neg ? -raw_hi : raw_hi;
      res_lo = (a_neg ^ b_neg) ? -raw_lo : raw_lo;
    end else begin
      res_hi = raw_hi;
      res_lo = raw_lo;
    end
  end

  assign busy      = (state == ST_RUN);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      counter   <= '0;
      acc       <= '0;
      mcand     <= '0;
      op_div    <= 1'b0;
      a_neg     <= 1'b0;
      b_neg     <= 1'b0;
      zero_pend <= 1'b0;
      hi_out    <= '0;
      lo_out    <= '0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        ST_IDLE: begin
          counter   <= '0;
          zero_pend <= 1'b0;
          if (ctrl == MD_MULT) begin
            op_div <= 1'b0;
            acc    <= {{WIDTH{1'b0}}, b_in, 1'b0};
            mcand  <= a_in;
            state  <= ST_RUN;
          end else if (ctrl == MD_DIV) begin
            op_div <= 1'b1;
            a_neg  <= a_in[WIDTH-1];
            b_neg  <= b_in[WIDTH-1];
            if (b_in == '0) begin
              zero_pend <= 1'b1;
              state     <= ST_DONE;
            end else begin
              acc   <= {{WIDTH{1'b0}}, a_abs, 1'b0};
              mcand <= b_abs;
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          acc     <= step_next;
          counter <= counter + CW'(1);
          if (counter == CW'(WIDTH-1)) begin
            hi_out <= res_hi;
            lo_out <= res_lo;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done     <= 1'b1;
          div_zero <= zero_pend;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed vector bench for mult_div_unit: table of operations plus reset/handshake sequences.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    logic         exp_dz;
    int           exp_lat;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   ctrl;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [W-1:0] hi_out;
  logic [W-1:0] lo_out;
  logic         busy;
  logic         done;
  logic         div_zero;
  md_state_t    fsm_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  vec_t vecs[14];

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk       (clk),
    .reset     (reset),
    .ctrl      (ctrl),
    .a_in      (a_in),
    .b_in      (b_in),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .fsm_state (fsm_state)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Waits for done after a start accepted at the previous edge; returns edges counted and busy cycles.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (lat < 100) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
    end
  endtask

  task automatic run_op(input string name, input vec_t v);
    int lat;
    int busy_cnt;
    logic [W-1:0] e_hi;
    logic [W-1:0] e_lo;
    exp_q.push_back(v.exp_hi);
    exp_q.push_back(v.exp_lo);
    @(negedge clk);
    ctrl = v.op;
    a_in = v.a;
    b_in = v.b;
    @(posedge clk);
    #1;
    ctrl = MD_IDLE;
    a_in = $urandom;
    b_in = $urandom;
    wait_done(lat, busy_cnt);
    e_hi = exp_q.pop_front();
    e_lo = exp_q.pop_front();
    check({name, " latency"}, W'(lat), W'(v.exp_lat));
    check({name, " hi"}, hi_out, e_hi);
    check({name, " lo"}, lo_out, e_lo);
    check({name, " div_zero"}, W'(div_zero), W'(v.exp_dz));
    check({name, " busy_cycles"}, W'(busy_cnt), W'(v.exp_lat == 1 ? 0 : 32));
    @(posedge clk);
    #1;
    check({name, " done_pulse"}, W'(done), '0);
  endtask

  initial begin
    int lat;
    int busy_cnt;
    logic seen;
    vec_t v;

    vecs[0]  = '{MD_MULT, 32'd3,         32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33};
    vecs[1]  = '{MD_MULT, 32'h80000000,  32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
    vecs[2]  = '{MD_MULT, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 33};
    vecs[3]  = '{MD_MULT, 32'h12345678,  32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 33};
    vecs[4]  = '{MD_MULT, 32'h7FFFFFFF,  32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 33};
    vecs[5]  = '{MD_MULT, 32'h80000000,  32'h00000001, 32'hFFFFFFFF, 32'h80000000, 1'b0, 33};
    vecs[6]  = '{MD_DIV,  32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
    vecs[7]  = '{MD_DIV,  32'd100,       32'd7,        32'd2,        32'd14,       1'b0, 33};
    vecs[8]  = '{MD_DIV,  32'd7,         32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 33};
    vecs[9]  = '{MD_DIV,  32'hFFFFFFF9,  32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        1'b0, 33};
    vecs[10] = '{MD_DIV,  32'h80000000,  32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
    vecs[11] = '{MD_DIV,  32'd3,         32'd5,        32'd3,        32'd0,        1'b0, 33};
    vecs[12] = '{MD_DIV,  32'd5,         32'd0,        32'd3,        32'd0,        1'b1, 1};
    vecs[13] = '{MD_MULT, 32'd0,         32'h00012345, 32'd0,        32'd0,        1'b0, 33};

    // Reset state
    reset = 1'b0;
    ctrl  = MD_IDLE;
    a_in  = '0;
    b_in  = '0;
    #12;
    check("reset hi", hi_out, '0);
    check("reset lo", lo_out, '0);
    check("reset busy", W'(busy), '0);
    check("reset done", W'(done), '0);
    check("reset div_zero", W'(div_zero), '0);
    check("reset state", W'(fsm_state), W'(ST_IDLE));
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i]);
    end

    // Reserved ctrl code must not start anything
    @(negedge clk);
    ctrl = MD_RSVD;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      seen = seen | busy | done;
    end
    ctrl = MD_IDLE;
    check("rsvd no_start", W'(seen), '0);

    // Reset in the middle of RUN (counter == 10)
    @(negedge clk);
    ctrl = MD_MULT;
    a_in = 32'd2;
    b_in = 32'd3;
    @(posedge clk);
    #1;
    ctrl = MD_IDLE;
    repeat (10) @(posedge clk);
    #1;
    check("mid busy_before", W'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("mid hi", hi_out, '0);
    check("mid lo", lo_out, '0);
    check("mid busy", W'(busy), '0);
    check("mid state", W'(fsm_state), W'(ST_IDLE));
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      seen = seen | done | div_zero;
    end
    check("mid no_done", W'(seen), '0);
    @(negedge clk);
    reset = 1'b1;
    v = '{MD_MULT, 32'd2, 32'd2, 32'd0, 32'd4, 1'b0, 33};
    run_op("after_reset", v);

    // Held ctrl restarts in the IDLE cycle after done; operand changes during RUN are ignored
    @(negedge clk);
    ctrl = MD_MULT;
    a_in = 32'd3;
    b_in = 32'd4;
    @(posedge clk);
    #1;
    wait_done(lat, busy_cnt);
    check("hold latency", W'(lat), 32'd33);
    check("hold lo", lo_out, 32'd12);
    check("hold busy_at_done", W'(busy), '0);
    @(posedge clk);
    #1;
    check("hold restart", W'(busy), 32'd1);
    ctrl = MD_IDLE;
    a_in = 32'hDEADBEEF;
    b_in = 32'h0BADF00D;
    wait_done(lat, busy_cnt);
    check("hold2 latency", W'(lat), 32'd33);
    check("hold2 hi", hi_out, '0);
    check("hold2 lo", lo_out, 32'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
